// File: rtl/product_accumulator_if.sv
// Bus between the multiplier/consumer side and product_accumulator.
//   tag_valid_in / tag_last_in : operand tag issued with each multiplier input pair
//   product_in                 : signed product straight from the multiplier output
//   out_data / out_valid       : FIFO head and non-empty flag
//   out_ready                  : consumer accept
//   fifo_count                 : FIFO occupancy
//   fifo_overflow              : sticky drop flag
// master = producer/consumer side, slave = accumulator.
interface product_accumulator_if #(
    parameter int PROD_W     = 19,
    parameter int OUT_W      = 11,
    parameter int FIFO_DEPTH = 4
);
    logic                             tag_valid_in;
    logic                             tag_last_in;
    logic signed [PROD_W-1:0]         product_in;
    logic signed [OUT_W-1:0]          out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [$clog2(FIFO_DEPTH):0]      fifo_count;
    logic                             fifo_overflow;

    modport master (
        output tag_valid_in, tag_last_in, product_in, out_ready,
        input  out_data, out_valid, fifo_count, fifo_overflow
    );

    modport slave (
        input  tag_valid_in, tag_last_in, product_in, out_ready,
        output out_data, out_valid, fifo_count, fifo_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
// Follows the pipelined 11x8 multiplier. A {valid,last} tag issued with each
// operand pair is delayed MULT_LATENCY cycles so it lines up with the product.
// Aligned products are summed per group; on "last" the group sum is rounded,
// arithmetically shifted by SHIFT and saturated to OUT_W bits, then queued in
// a show-ahead FIFO.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : product_accumulator_if.slave (tags, product, FIFO output side)
// No backpressure toward the multiplier: a full FIFO drops the result and
// sets the sticky fifo_overflow flag. MULT_LATENCY must be at least 2.
module product_accumulator #(
    parameter int PROD_W       = 19,
    parameter int MULT_LATENCY = 9,
    parameter int ACC_W        = 24,
    parameter int SHIFT        = 7,
    parameter int OUT_W        = 11,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    product_accumulator_if.slave   bus
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] ROUND_ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0] ROUND_BIAS = (SHIFT > 0) ? (ROUND_ONE << BIAS_SH) : '0;

    // ------------------------------------------------------------------
    // Tag delay line; last is qualified with valid on entry.
    // ------------------------------------------------------------------
    logic [MULT_LATENCY-1:0] r_tag_valid;
    logic [MULT_LATENCY-1:0] r_tag_last;
    logic                    w_al_valid;
    logic                    w_al_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid <= '0;
            r_tag_last  <= '0;
        end else begin
            r_tag_valid <= {r_tag_valid[MULT_LATENCY-2:0], bus.tag_valid_in};
            r_tag_last  <= {r_tag_last[MULT_LATENCY-2:0],
                            bus.tag_valid_in & bus.tag_last_in};
        end
    end

    assign w_al_valid = r_tag_valid[MULT_LATENCY-1];
    assign w_al_last  = r_tag_last[MULT_LATENCY-1];

    // ------------------------------------------------------------------
    // Accumulator and group-sum register (wraps modulo 2^ACC_W).
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_stage_sum;
    logic                    r_stage_valid;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_sum;

    assign w_term = {{(ACC_W-PROD_W){bus.product_in[PROD_W-1]}}, bus.product_in};
    assign w_sum  = r_acc + w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_stage_sum   <= '0;
            r_stage_valid <= 1'b0;
        end else begin
            r_stage_valid <= w_al_valid & w_al_last;
            if (w_al_valid && w_al_last) begin
                r_stage_sum <= w_sum;
                r_acc       <= '0;
            end else if (w_al_valid) begin
                r_acc <= w_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round half-up, shift, saturate. One extra bit so the bias add on a
    // near-full-scale positive sum cannot wrap.
    // ------------------------------------------------------------------
    logic signed [ACC_W:0]         w_biased;
    logic signed [ACC_W:0]         w_shifted;
    logic [ACC_W-OUT_W+1:0]        w_upper;
    logic [OUT_W-1:0]              w_result;

    assign w_biased  = {r_stage_sum[ACC_W-1], r_stage_sum} + ROUND_BIAS;
    assign w_shifted = w_biased >>> SHIFT;
    // In range only when every bit above the output sign bit matches it.
    assign w_upper   = w_shifted[ACC_W:OUT_W-1];

    always_comb begin
        w_result = w_shifted[OUT_W-1:0];
        if (!((&w_upper) || (~|w_upper))) begin
            w_result = w_shifted[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead output FIFO.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;

    assign w_pop  = (r_count != '0) & bus.out_ready;
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign w_push = r_stage_valid & (~w_full | w_pop);
    assign w_drop = r_stage_valid & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head is forced to zero when empty so stale entries never show.
    assign bus.out_valid     = (r_count != '0);
    assign bus.out_data      = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.fifo_count    = r_count;
    assign bus.fifo_overflow = r_overflow;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic clk;
    logic rst;
    logic signed [18:0] prod_issue;
    logic signed [18:0] prod_pipe [9];
    int total;
    int bad;

    product_accumulator_if #(.PROD_W(19), .OUT_W(11), .FIFO_DEPTH(4)) bus_a ();
    product_accumulator_if #(.PROD_W(19), .OUT_W(11), .FIFO_DEPTH(4)) bus_b ();

    product_accumulator #(.SHIFT(7)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    product_accumulator #(.SHIFT(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the 9-cycle multiplier: what is issued appears 9 cycles later.
    always @(posedge clk) begin
        prod_pipe[0] <= prod_issue;
        for (int i = 1; i < 9; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
    assign bus_a.product_in = prod_pipe[8];
    assign bus_b.product_in = prod_pipe[8];

    localparam logic signed [18:0] JUNK = 19'sh2AAAA;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag(input logic v, input logic l, input logic signed [18:0] p);
        bus_a.tag_valid_in = v;
        bus_b.tag_valid_in = v;
        bus_a.tag_last_in  = l;
        bus_b.tag_last_in  = l;
        prod_issue         = p;
    endtask

    task automatic set_ready(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    task automatic issue(input logic l, input logic signed [18:0] p);
        set_tag(1'b1, l, p);
        tick();
        set_tag(1'b0, 1'b1, JUNK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a result at the head, checks it, and lets it pop.
    task automatic get_result(input string tag, input int exp_a,
                              input bit use_b, input int exp_b);
        int n;
        n = 0;
        while (bus_a.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, bus_a.out_valid, 1);
        chk({tag, "_dat"}, bus_a.out_data, exp_a);
        if (use_b) begin
            chk({tag, "_vld_b"}, bus_b.out_valid, 1);
            chk({tag, "_dat_b"}, bus_b.out_data, exp_b);
        end
        tick();
    endtask

    initial begin
        int seen;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_tag(1'b0, 1'b0, JUNK);
        set_ready(1'b1);
        do_reset();

        // Reset state
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_data", bus_a.out_data, 0);
        chk("rst_count", bus_a.fifo_count, 0);
        chk("rst_ovf", bus_a.fifo_overflow, 0);

        // Basic group with latency: 1000+2000-500 = 2500 -> (2500+64)>>7 = 20
        set_ready(1'b0);
        issue(1'b0, 19'sd1000);
        issue(1'b0, 19'sd2000);
        issue(1'b1, -19'sd500);
        idle(9);
        chk("lat_early", bus_a.out_valid, 0);
        tick();
        chk("lat_valid", bus_a.out_valid, 1);
        chk("lat_data", bus_a.out_data, 20);
        chk("lat_count", bus_a.fifo_count, 1);
        set_ready(1'b1);
        tick();
        chk("pop_count", bus_a.fifo_count, 0);
        chk("pop_valid", bus_a.out_valid, 0);

        // Saturation both ways
        issue(1'b0, 19'sd262143);
        issue(1'b0, 19'sd262143);
        issue(1'b1, 19'sd262143);
        issue(1'b0, -19'sd262144);
        issue(1'b0, -19'sd262144);
        issue(1'b1, -19'sd262144);
        get_result("sat_pos", 1023, 1'b0, 0);
        get_result("sat_neg", -1024, 1'b0, 0);

        // Rounding edges, single-term groups back to back
        issue(1'b1, 19'sd64);
        issue(1'b1, -19'sd64);
        issue(1'b1, -19'sd65);
        issue(1'b1, 19'sd63);
        get_result("rnd_p64", 1, 1'b0, 0);
        get_result("rnd_m64", 0, 1'b0, 0);
        get_result("rnd_m65", -1, 1'b0, 0);
        get_result("rnd_p63", 0, 1'b0, 0);

        // Back-to-back groups {10,20},{-5}; SHIFT=0 instance gives raw sums
        issue(1'b0, 19'sd10);
        issue(1'b1, 19'sd20);
        issue(1'b1, -19'sd5);
        get_result("bb_g1", 0, 1'b1, 30);
        get_result("bb_g2", 0, 1'b1, -5);

        // Overflow: five results into a 4-deep FIFO with no consumer
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) issue(1'b1, 19'sd128);
        idle(15);
        chk("ovf_count", bus_a.fifo_count, 4);
        chk("ovf_flag", bus_a.fifo_overflow, 1);
        chk("ovf_head", bus_a.out_data, 1);
        set_ready(1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_vld", bus_a.out_valid, 1);
            chk("drain_dat", bus_a.out_data, 1);
            chk("drain_cnt", bus_a.fifo_count, 4 - i);
            tick();
        end
        chk("drain_empty", bus_a.fifo_count, 0);
        chk("drain_novld", bus_a.out_valid, 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        chk("rst2_ovf", bus_a.fifo_overflow, 0);
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) issue(1'b1, 19'sd128);
        idle(15);
        chk("full_count", bus_a.fifo_count, 4);
        issue(1'b1, 19'sd128);
        idle(9);
        set_ready(1'b1);
        tick();
        set_ready(1'b0);
        chk("pp_count", bus_a.fifo_count, 4);
        chk("pp_ovf", bus_a.fifo_overflow, 0);
        idle(3);
        chk("pp_count2", bus_a.fifo_count, 4);
        set_ready(1'b1);
        idle(5);
        chk("pp_drained", bus_a.fifo_count, 0);
        chk("pp_ovf2", bus_a.fifo_overflow, 0);

        // Reset mid-flight (tags in pipe) and mid-group (partial sum held)
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, 19'sd1000);
            issue(1'b0, 19'sd1000);
            idle(k == 0 ? 4 : 11);
            do_reset();
            chk("mid_rst_cnt", bus_a.fifo_count, 0);
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (bus_a.out_valid !== 1'b0) seen++;
                tick();
            end
            chk("mid_rst_noout", seen, 0);
            chk("mid_rst_ovf", bus_a.fifo_overflow, 0);
            issue(1'b1, 19'sd256);
            get_result("after_rst", 2, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sits directly downstream of the 11x8 signed pipelined multiplier (9-cycle latency, no valid/stall).
- Delays a valid/last tag issued alongside each operand pair so it aligns with the product.
- Sums the aligned 19-bit products over a group ending on "last", then rounds, shifts and saturates the group sum to a screen/coordinate word.
- Queues results in a small show-ahead FIFO with a valid/ready output.

Parameters:
PROD_W, 19, width of signed product from multiplier
MULT_LATENCY, 9, cycles from operand presentation to product on multiplier output
ACC_W, 24, signed accumulator width (safe for up to 32 full-scale terms)
SHIFT, 7, arithmetic right shift applied to group sum (0 = no shift, no rounding)
OUT_W, 11, signed output width after saturation
FIFO_DEPTH, 4, output FIFO entries (power of two)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
tag_valid_in  input  1  high in the same cycle operands are presented to the multiplier
tag_last_in  input  1  marks final term of a group; ignored when tag_valid_in=0
product_in  input  PROD_W  signed product straight from multiplier output
out_data  output  OUT_W  signed result at FIFO head
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts out_data when out_valid&out_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
fifo_overflow  output  1  sticky; set when a result is dropped because FIFO full

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst. Reset clears the tag delay line, accumulator, round stage, FIFO pointers/count and fifo_overflow. All outputs read 0 the cycle after reset.
- Tag alignment: MULT_LATENCY-stage shift register of {valid,last}. The tag presented at cycle t is visible at cycle t+MULT_LATENCY, together with product_in for that operand pair.
- Accumulate: on an aligned valid, term = sign-extend(product_in) to ACC_W.
  - If not last: acc <= acc + term.
  - If last: group_sum = acc + term is registered into the round stage with stage_valid=1, and acc <= 0.
  - Aligned valid=0: acc holds.
  - Acc wraps modulo 2^ACC_W; no error flag.
- Round stage (1 cycle): r = (group_sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, computed at ACC_W+1 bits to avoid overflow.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Result is pushed into the FIFO on the next edge when stage_valid.
- Latency: last operand at cycle t -> out_valid high at t+MULT_LATENCY+2 (t+11 default) if FIFO empty and not stalled.
- FIFO behaviour:
  - Show-ahead: out_data is the head whenever out_valid.
  - Pop on out_valid&out_ready.
  - Push when stage_valid.
  - Simultaneous push and pop when full is allowed: pop frees the slot, push accepted, count unchanged.
  - Push when full without pop: result dropped, count unchanged, fifo_overflow set until rst.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Input never stalls. The block accepts one product per cycle indefinitely; there is no backpressure toward the multiplier.
- Single-term groups (valid&last on the first term) are legal. Back-to-back groups with no idle cycle are legal; each new group starts from acc=0.
- Reset mid-group or mid-flight: the partial sum and in-flight tags are discarded. Products still emerging from the multiplier after reset carry valid=0 and are ignored.
- fifo_count and out_valid are registered, derived from pointers/count. No combinational path from out_ready to out_valid.

Test Plan:
- Group of products 1000, 2000, -500 (last on third), SHIFT=7 -> sum 2500, out_data=20, out_valid at last-operand cycle+11, fifo_count=1.
- Three products of 262143 -> 786429 -> out_data=1023 (positive saturation); three of -262144 -> out_data=-1024.
- Rounding edges as single-term groups: 64 -> 1, -64 -> 0, -65 -> -1, 63 -> 0.
- Two back-to-back groups {10,20} and {-5} (no idle cycles) -> results 0 and 0 with SHIFT=7. Repeat with SHIFT=0 -> 30 then -5, in order.
- out_ready=0, issue 5 single-term groups of 128 -> fifo_count=4, fifo_overflow=1, 5th result lost. Then out_ready=1 -> four 1's popped on consecutive cycles, count returns to 0. Full plus simultaneous push/pop -> count stays 4, no overflow.
- rst asserted after 2 of 3 terms issued -> no output ever appears for that group, fifo_overflow=0. The next group {256} after reset -> out_data=2.
